trigger_generator: RTL and testbench
====================================

TRIGGER_GENERATOR -- requirements
Module: trigger_generator

Interface
REQ-001 Parameter: N, default 3, width of the trigger tag carried on data_out.
REQ-002 clk  input  1  system clock; all logic SHALL be synchronous to clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sync  input  1  clock enable; the state, counters, trg_out and data_out SHALL change only on clk edges with sync=1.
REQ-005 start  input  1  request a trigger sequence; a one-clk pulse is sufficient.
REQ-006 stop  input  1  abort request; a one-clk pulse is sufficient.
REQ-007 period  input  16  spacing between triggers, in sync ticks.
REQ-008 burst  input  8  number of triggers per sequence; 0 = continuous.
REQ-009 trg_out  output  1  registered trigger, high for exactly one sync tick per trigger.
REQ-010 data_out  output  N  registered trigger tag; valid while trg_out=1, otherwise 0.
REQ-011 busy  output  1  high while a sequence is running.

Function
REQ-012 start_pend SHALL be set on any clk edge with start=1 and cleared when consumed, so a start between sync ticks is never lost.
REQ-013 stop_pend SHALL be set on any clk edge with stop=1 and cleared on the next sync tick.
REQ-014 States: IDLE and RUN; busy SHALL be 1 exactly when state=RUN.
REQ-015 IDLE, sync tick, start_pend=1, stop_pend=0: next state RUN; trg_out<=1; data_out<=tag; tag<=tag+1; remaining<=burst-1 (burst sampled here only); gap<=max(period,1)-1; start_pend cleared.
REQ-016 RUN, sync tick, gap!=0: gap<=gap-1; trg_out<=0; data_out<=0.
REQ-017 RUN, sync tick, gap=0, not last: fire as in REQ-015 (tag, gap reload from current period); remaining decremented unless continuous.
REQ-018 Last trigger already issued (remaining=0, burst!=0) and gap=0 at a sync tick: trg_out<=0, data_out<=0, state IDLE.
REQ-019 Trigger spacing SHALL be exactly max(period,1) sync ticks; period=0 and period=1 both give one trigger per sync tick, with trg_out held high continuously.
REQ-020 tag: N-bit counter, SHALL wrap from 2^N-1 to 0, SHALL NOT be cleared by start or stop.
REQ-021 Stop: at the next sync tick with stop_pend=1, the block SHALL clear trg_out and data_out, enter IDLE, and clear start_pend, in any state.
REQ-022 start and stop in the same clk, or both pending at one sync tick: stop SHALL win; no trigger is issued.
REQ-023 start_pend set while RUN SHALL be cleared at the next sync tick without effect.
REQ-024 Changes of period SHALL take effect at the next gap reload; changes of burst SHALL take effect only at the next start.
REQ-025 With sync=0, all outputs SHALL hold their values indefinitely.

Reset
REQ-026 reset=1 SHALL immediately force: state=IDLE, trg_out=0, data_out=0, busy=0, tag=0, gap=0, remaining=0, start_pend=0, stop_pend=0.
REQ-027 Reset asserted mid-sequence SHALL abort it; after release, no trigger SHALL occur before a new start.

Verification
REQ-028 Setup: sync every 4th clk, period=3, burst=2; pulse start between sync ticks. Required: triggers at sync ticks 0 and 3 with data_out=0 and 1; each trigger high for 4 clk; busy drops at tick 6.
REQ-029 Setup: N=3, period=1, burst=10. Required: trg_out high for 10 consecutive sync ticks; data_out runs 0..7,0,1.
REQ-030 Setup: burst=0, period=5; stop after the 3rd trigger. Required: no further triggers; busy=0 at the next sync tick; the next start issues tag 3.
REQ-031 Setup: start and stop in the same clk while IDLE. Required: trg_out stays 0 and busy stays 0.
REQ-032 Setup: reset asserted while RUN with trg_out=1. Required: trg_out=0, data_out=0, busy=0 immediately, before any clk edge; the next start issues tag 0.
REQ-033 Setup: period changed from 4 to 2 during the gap. Required: the current gap completes at 4; subsequent spacing is 2.

Source files
------------

// File: rtl/trigger_generator.sv
// Trigger sequencer: issues bursts (or continuous streams) of one-tick triggers
// spaced by a programmable number of sync ticks, each tagged with a wrapping counter.
module trigger_generator #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sync,
  input  logic         start,
  input  logic         stop,
  input  logic [15:0]  period,
  input  logic [7:0]   burst,
  output logic         trg_out,
  output logic [N-1:0] data_out,
  output logic         busy,
  output logic         dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic           trg_q, trg_d;
  logic [N-1:0]   data_q, data_d;
  logic [N-1:0]   tag_q, tag_d;
  logic [15:0]    gap_q, gap_d;
  logic [7:0]     rem_q, rem_d;
  logic           cont_q, cont_d;
  logic           start_pend_q, start_pend_d;
  logic           stop_pend_q, stop_pend_d;

  logic           start_req;
  logic           stop_req;
  logic [15:0]    gap_reload;

  // A request seen on the same edge as a sync tick acts on that tick.
  assign start_req  = start_pend_q | start;
  assign stop_req   = stop_pend_q | stop;
  assign gap_reload = (period == 16'd0) ? 16'd0 : period - 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      trg_q        <= 1'b0;
      data_q       <= '0;
      tag_q        <= '0;
      gap_q        <= '0;
      rem_q        <= '0;
      cont_q       <= 1'b0;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      trg_q        <= trg_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      gap_q        <= gap_d;
      rem_q        <= rem_d;
      cont_q       <= cont_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    trg_d        = trg_q;
    data_d       = data_q;
    tag_d        = tag_q;
    gap_d        = gap_q;
    rem_d        = rem_q;
    cont_d       = cont_q;
    start_pend_d = start_pend_q;
    stop_pend_d  = stop_pend_q;

    if (!sync) begin
      start_pend_d = start_req;
      stop_pend_d  = stop_req;
    end else begin
      // Every sync tick consumes both pending flags, whatever the state.
      start_pend_d = 1'b0;
      stop_pend_d  = 1'b0;
      trg_d        = 1'b0;
      data_d       = '0;
      if (stop_req) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_req) begin
              state_d = S_RUN;
              trg_d   = 1'b1;
              data_d  = tag_q;
              tag_d   = tag_q + 1'b1;
              gap_d   = gap_reload;
              rem_d   = burst - 8'd1;
              cont_d  = (burst == 8'd0);
            end
          end
          S_RUN: begin
            if (gap_q != 16'd0) begin
              gap_d = gap_q - 16'd1;
            end else if (!cont_q && rem_q == 8'd0) begin
              state_d = S_IDLE;
            end else begin
              trg_d  = 1'b1;
              data_d = tag_q;
              tag_d  = tag_q + 1'b1;
              gap_d  = gap_reload;
              if (!cont_q) rem_d = rem_q - 8'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign trg_out     = trg_q;
  assign data_out    = data_q;
  assign busy        = (state_q == S_RUN);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trigger_generator.sv
// Directed bench for trigger_generator: sync every 4th clk, expected
// {busy, trg_out, data_out} per sync tick queued ahead and checked on all 4 clks.
module tb_trigger_generator;

  localparam int N = 3;
  localparam int W = N + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sync = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [15:0]  period = 16'd0;
  logic [7:0]   burst = 8'd0;
  logic         trg_out;
  logic [N-1:0] data_out;
  logic         busy;
  logic         dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  trigger_generator #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .start      (start),
    .stop       (stop),
    .period     (period),
    .burst      (burst),
    .trg_out    (trg_out),
    .data_out   (data_out),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic b, input logic t, input logic [N-1:0] d);
    exp_q.push_back({b, t, d});
  endtask

  // One sync tick (optionally with start/stop on the same edge) followed by
  // three non-sync clks during which every output must hold.
  task automatic do_tick(input string tag, input logic s, input logic p);
    logic [W-1:0] e;
    @(negedge clk);
    sync = 1'b1; start = s; stop = p;
    @(posedge clk);
    #1;
    sync = 1'b0; start = 1'b0; stop = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin
          @(posedge clk);
          #1;
        end
        check(tag, {busy, trg_out, data_out}, e);
      end
    end
  endtask

  // Drive start/stop for one clk between sync ticks.
  task automatic pulse(input logic s, input logic p);
    @(negedge clk);
    sync = 1'b0; start = s; stop = p;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_outputs", {busy, trg_out, data_out}, '0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("reset_state", {busy, trg_out, data_out}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Burst of 2, period 3, start between ticks
    period = 16'd3; burst = 8'd2;
    pulse(1'b1, 1'b0);
    push_exp(1, 1, 0); push_exp(1, 0, 0); push_exp(1, 0, 0);
    push_exp(1, 1, 1); push_exp(1, 0, 0); push_exp(1, 0, 0);
    push_exp(0, 0, 0); push_exp(0, 0, 0);
    repeat (8) do_tick("burst2_p3", 1'b0, 1'b0);

    // Period 1, burst 10: tag wraps 7 -> 0
    do_reset();
    period = 16'd1; burst = 8'd10;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) push_exp(1, 1, 3'(i));
    push_exp(0, 0, 0);
    repeat (11) do_tick("burst10_p1", 1'b0, 1'b0);

    // Continuous, period 5, stop after third trigger
    do_reset();
    period = 16'd5; burst = 8'd0;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 1, 3'(i));
      if (i < 2) repeat (4) push_exp(1, 0, 0);
    end
    repeat (11) do_tick("cont_p5", 1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    repeat (3) push_exp(0, 0, 0);
    repeat (3) do_tick("after_stop", 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    push_exp(1, 1, 3);
    do_tick("restart_tag3", 1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    push_exp(0, 0, 0);
    do_tick("stop2", 1'b0, 1'b0);

    // Start and stop together, on a sync edge and between ticks
    push_exp(0, 0, 0);
    do_tick("start_stop_sync_edge", 1'b1, 1'b1);
    pulse(1'b1, 1'b1);
    push_exp(0, 0, 0); push_exp(0, 0, 0);
    repeat (2) do_tick("start_stop_between", 1'b0, 1'b0);

    // Reset while trg_out is high, then no trigger until a new start
    period = 16'd2; burst = 8'd0;
    pulse(1'b1, 1'b0);
    push_exp(1, 1, 4);
    do_tick("pre_reset_fire", 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid_run", {busy, trg_out, data_out}, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) push_exp(0, 0, 0);
    repeat (3) do_tick("post_reset_idle", 1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    push_exp(1, 1, 0); push_exp(1, 0, 0);
    repeat (2) do_tick("post_reset_tag0", 1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    push_exp(0, 0, 0);
    do_tick("stop3", 1'b0, 1'b0);

    // Period 4 -> 2 during a gap; redundant start while running is ignored
    period = 16'd4; burst = 8'd0;
    pulse(1'b1, 1'b0);
    push_exp(1, 1, 1); push_exp(1, 0, 0);
    repeat (2) do_tick("period4", 1'b0, 1'b0);
    period = 16'd2;
    pulse(1'b1, 1'b0);
    push_exp(1, 0, 0); push_exp(1, 0, 0);
    push_exp(1, 1, 2); push_exp(1, 0, 0);
    push_exp(1, 1, 3); push_exp(1, 0, 0);
    push_exp(1, 1, 4);
    repeat (7) do_tick("period_change", 1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    push_exp(0, 0, 0); push_exp(0, 0, 0);
    repeat (2) do_tick("final_stop", 1'b0, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drained: observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
